// File: rtl/frame_monitor_if.sv
// -----------------------------------------------------------------------------
// frame_monitor_if
//
// Purpose:
//   Register bus bundle used to access the frame_monitor counter/control block.
//   A command is a single-cycle strobe; reads return data on the following edge.
//
// Signals:
//   bus_cmd_valid  command strobe, one cycle per command
//   bus_op         1 = write, 0 = read
//   bus_addr       16-bit register address
//   bus_wr_data    16-bit write data
//   bus_rd_data    16-bit registered read data (driven by the slave)
//
// Modports:
//   master  issues commands, receives read data
//   slave   receives commands, returns read data
// -----------------------------------------------------------------------------
interface frame_monitor_if;

    logic        bus_cmd_valid;
    logic        bus_op;
    logic [15:0] bus_addr;
    logic [15:0] bus_wr_data;
    logic [15:0] bus_rd_data;

    modport master (
        output bus_cmd_valid,
        output bus_op,
        output bus_addr,
        output bus_wr_data,
        input  bus_rd_data
    );

    modport slave (
        input  bus_cmd_valid,
        input  bus_op,
        input  bus_addr,
        input  bus_wr_data,
        output bus_rd_data
    );

endinterface

// File: rtl/frame_monitor.sv
// -----------------------------------------------------------------------------
// frame_monitor
//
// Purpose:
//   Watches a byte stream (rxd qualified by rx_dv) and measures each frame,
//   where a frame is one contiguous run of rx_dv=1. For every frame that starts
//   while monitoring is enabled it produces a one-cycle frame_done pulse with a
//   runt/long error flag, updates saturating statistics counters and records
//   the length and 8-bit additive checksum of the most recent frame. The
//   statistics are visible through a small 16-bit register bus.
//
// Parameters:
//   MIN_LEN   frames shorter than this many bytes are runts
//   MAX_LEN   frames longer than this many bytes are long
//
// Ports:
//   i_clk           clock, all logic on the rising edge
//   i_rst           synchronous active-high reset
//   bus_if          register bus (slave side), see frame_monitor_if
//   i_rxd           byte stream
//   i_rx_dv         byte valid
//   o_frame_done    one-cycle pulse per counted frame
//   o_frame_err     valid with o_frame_done; 1 = runt or long
//
// Register map (16-bit):
//   0x10 frame_cnt           0x14 long_cnt
//   0x11 byte_cnt[15:0]      0x15 last_len
//   0x12 byte_cnt[31:16]     0x16 {8'b0, last_csum}
//   0x13 runt_cnt            0x17 ctrl {14'b0, clear, enable} (only writable reg)
// -----------------------------------------------------------------------------
module frame_monitor #(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    frame_monitor_if.slave        bus_if,
    input  logic [7:0]            i_rxd,
    input  logic                  i_rx_dv,
    output logic                  o_frame_done,
    output logic                  o_frame_err
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    localparam logic [15:0] ADDR_FRAME_CNT = 16'h0010;
    localparam logic [15:0] ADDR_BYTE_LO   = 16'h0011;
    localparam logic [15:0] ADDR_BYTE_HI   = 16'h0012;
    localparam logic [15:0] ADDR_RUNT_CNT  = 16'h0013;
    localparam logic [15:0] ADDR_LONG_CNT  = 16'h0014;
    localparam logic [15:0] ADDR_LAST_LEN  = 16'h0015;
    localparam logic [15:0] ADDR_LAST_CSUM = 16'h0016;
    localparam logic [15:0] ADDR_CTRL      = 16'h0017;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [15:0] r_len;
    logic [7:0]  r_csum;
    logic        r_active;      // enable latched at frame start

    logic        r_enable;
    logic [15:0] r_frame_cnt;
    logic [31:0] r_byte_cnt;
    logic [15:0] r_runt_cnt;
    logic [15:0] r_long_cnt;
    logic [15:0] r_last_len;
    logic [7:0]  r_last_csum;

    logic [15:0] r_rd_data;
    logic        r_frame_done;
    logic        r_frame_err;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic        w_frame_end;
    logic        w_count;
    logic        w_runt;
    logic        w_long;
    logic        w_rd_cmd;
    logic        w_wr_ctrl;
    logic        w_clear;
    logic [32:0] w_byte_sum;
    logic [31:0] w_byte_next;
    logic [15:0] w_rd_mux;

    // First cycle with rx_dv low while receiving closes the frame.
    assign w_frame_end = (r_state == S_RECV) && !i_rx_dv;
    assign w_count     = w_frame_end && r_active;

    // Compare at 32 bits so the parameters are never truncated.
    assign w_runt = (32'(r_len) < MIN_LEN);
    assign w_long = (32'(r_len) > MAX_LEN);

    assign w_rd_cmd  = bus_if.bus_cmd_valid && !bus_if.bus_op;
    assign w_wr_ctrl = bus_if.bus_cmd_valid && bus_if.bus_op
                       && (bus_if.bus_addr == ADDR_CTRL);
    assign w_clear   = w_wr_ctrl && bus_if.bus_wr_data[1];

    // Saturating 32-bit byte accumulation: a carry out of bit 31 pins to all-ones.
    assign w_byte_sum  = {1'b0, r_byte_cnt} + {17'b0, r_len};
    assign w_byte_next = w_byte_sum[32] ? 32'hFFFF_FFFF : w_byte_sum[31:0];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Read mux sees the current (pre-update) register values.
    always_comb begin
        w_rd_mux = 16'h0000;
        case (bus_if.bus_addr)
            ADDR_FRAME_CNT: w_rd_mux = r_frame_cnt;
            ADDR_BYTE_LO:   w_rd_mux = r_byte_cnt[15:0];
            ADDR_BYTE_HI:   w_rd_mux = r_byte_cnt[31:16];
            ADDR_RUNT_CNT:  w_rd_mux = r_runt_cnt;
            ADDR_LONG_CNT:  w_rd_mux = r_long_cnt;
            ADDR_LAST_LEN:  w_rd_mux = r_last_len;
            ADDR_LAST_CSUM: w_rd_mux = {8'h00, r_last_csum};
            ADDR_CTRL:      w_rd_mux = {14'b0, 1'b0, r_enable};  // clear is self-clearing
            default:        w_rd_mux = 16'h0000;
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame receive FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_len    <= 16'h0000;
            r_csum   <= 8'h00;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_rx_dv) begin
                        r_state  <= S_RECV;
                        r_len    <= 16'd1;
                        r_csum   <= i_rxd;
                        r_active <= r_enable;
                    end
                end
                S_RECV: begin
                    if (i_rx_dv) begin
                        r_len  <= sat_inc16(r_len);
                        r_csum <= r_csum + i_rxd;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame result pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= w_count;
            r_frame_err  <= w_count && (w_runt || w_long);
        end
    end

    // -------------------------------------------------------------------------
    // Last-frame capture (not affected by clear)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_len  <= 16'h0000;
            r_last_csum <= 8'h00;
        end else if (w_count) begin
            r_last_len  <= r_len;
            r_last_csum <= r_csum;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters; clear is applied after the update so it wins
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt <= 16'h0000;
            r_byte_cnt  <= 32'h0000_0000;
            r_runt_cnt  <= 16'h0000;
            r_long_cnt  <= 16'h0000;
        end else begin
            if (w_count) begin
                r_frame_cnt <= sat_inc16(r_frame_cnt);
                r_byte_cnt  <= w_byte_next;
                if (w_runt) begin
                    r_runt_cnt <= sat_inc16(r_runt_cnt);
                end
                if (w_long) begin
                    r_long_cnt <= sat_inc16(r_long_cnt);
                end
            end
            if (w_clear) begin
                r_frame_cnt <= 16'h0000;
                r_byte_cnt  <= 32'h0000_0000;
                r_runt_cnt  <= 16'h0000;
                r_long_cnt  <= 16'h0000;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_enable <= 1'b1;
        end else if (w_wr_ctrl) begin
            r_enable <= bus_if.bus_wr_data[0];
        end
    end

    // -------------------------------------------------------------------------
    // Registered read data; holds when no read is issued
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= 16'h0000;
        end else if (w_rd_cmd) begin
            r_rd_data <= w_rd_mux;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus_if.bus_rd_data = r_rd_data;
    assign o_frame_done       = r_frame_done;
    assign o_frame_err        = r_frame_err;

endmodule

// File: doc/frame_monitor.md
FRAME_MONITOR -- requirements
Module: frame_monitor

Interface
REQ-001 Parameter MIN_LEN, 60, frames shorter than this many bytes SHALL be classed runt.
REQ-002 Parameter MAX_LEN, 1518, frames longer than this many bytes SHALL be classed long.
REQ-003 clk  input  1  sole clock; all logic SHALL be on the rising edge.
REQ-004 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 bus_cmd_valid  input  1  bus command strobe, one cycle per command.
REQ-006 bus_op  input  1  1 = write, 0 = read.
REQ-007 bus_addr  input  16  register address.
REQ-008 bus_wr_data  input  16  write data.
REQ-009 bus_rd_data  output  16  read data, registered.
REQ-010 rxd  input  8  byte stream from the upstream pass/invert stage (its txd).
REQ-011 rx_dv  input  1  byte valid from upstream (its tx_en); a frame is one contiguous run of rx_dv=1.
REQ-012 frame_done  output  1  one-cycle pulse per counted frame.
REQ-013 frame_err  output  1  valid with frame_done; 1 = runt or long.

Function
REQ-014 FSM SHALL have states IDLE and RECV; IDLE->RECV when rx_dv=1, RECV->IDLE when rx_dv=0.
REQ-015 On IDLE->RECV the block SHALL load len=1, csum=rxd, and latch active=ctrl.enable; enable changes mid-frame SHALL NOT affect that frame.
REQ-016 In RECV with rx_dv=1: len+=1 saturating at 16'hFFFF; csum=(csum+rxd) mod 256.
REQ-017 On RECV->IDLE (first cycle rx_dv=0 sampled), if active, the block SHALL register on that edge: frame_done=1, frame_err=(len<MIN_LEN)||(len>MAX_LEN), counter updates, last_len=len, last_csum=csum; frame_done/frame_err SHALL be 0 on every other cycle.
REQ-018 Per counted frame: frame_cnt+=1; byte_cnt (32-bit)+=len; runt_cnt+=1 if runt; long_cnt+=1 if long; every counter SHALL saturate at all-ones, never wrap.
REQ-019 A length of exactly MIN_LEN or MAX_LEN SHALL be good.
REQ-020 Register map (16-bit): 0x10 frame_cnt; 0x11 byte_cnt[15:0]; 0x12 byte_cnt[31:16]; 0x13 runt_cnt; 0x14 long_cnt; 0x15 last_len; 0x16 {8'b0,last_csum}; 0x17 ctrl {14'b0,clear,enable}.
REQ-021 Read (bus_cmd_valid=1, bus_op=0): bus_rd_data SHALL update on the next edge (1-cycle latency); unmapped address SHALL return 16'h0; with no read command bus_rd_data SHALL hold.
REQ-022 A read on the same edge as a counter update SHALL return the pre-update value.
REQ-023 Write to 0x17: enable=wr_data[0]; wr_data[1]=1 SHALL zero frame_cnt, byte_cnt, runt_cnt, long_cnt on that edge; clear bit SHALL read back as 0.
REQ-024 Clear coincident with a frame end: counters SHALL be zero afterward (clear wins); last_len, last_csum and frame_done SHALL still update.
REQ-025 Writes to any other address SHALL be ignored; only 0x17 is writable.
REQ-026 A frame in progress when rst asserts SHALL be discarded without frame_done.

Reset
REQ-027 While rst=1: state=IDLE, all counters, last_len, last_csum, bus_rd_data, frame_done, frame_err = 0; enable=1.
REQ-028 If rx_dv=1 on the first cycle after rst deasserts, that cycle SHALL start a frame.

Verification
REQ-029 Reset, 64-byte frame of bytes 0x01 -> frame_done=1, frame_err=0 one cycle after rx_dv falls; read 0x10=1, 0x11=64, 0x15=64, 0x16=0x40.
REQ-030 Frames of 59, 60, 1518, 1519 bytes -> 0x13=1, 0x14=1, 0x10=4, frame_err pulses 1,0,0,1.
REQ-031 Write 0x17=0x0, send 64-byte frame -> no frame_done, 0x10 unchanged; write 0x17=0x1 mid-frame -> that frame still ignored.
REQ-032 Write 0x17=0x3 on the frame-end edge of a 100-byte frame -> 0x10=0, 0x11=0, 0x15=100, frame_done=1; read 0x17 -> 0x1.
REQ-033 Assert rst for one cycle mid-frame after 30 bytes, then send 64-byte frame -> one frame_done only, 0x15=64.
REQ-034 Byte counter carry: preload via 1000 frames totalling >65535 bytes -> 0x12 nonzero, {0x12,0x11} equals exact byte sum; read unmapped 0x20 -> 0.
